fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage; directly upstream of the instruction decoder. Holds the PC and
//  issues one-outstanding-request reads to instruction memory (variable latency, req/ack).
//  Presents the 16-bit instruction plus PC+2 to decode through a 1-entry valid/ready buffer.
//  Applies execute-stage redirects (branch/jump) and stops fetching after a HALT is consumed.
// PARAMETERS
//  PC_W      16       PC / address width
//  INSTR_W   16       instruction width
//  RESET_PC  16'h0000 PC loaded on reset
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst            in   1        synchronous, active-high reset
//  imem_req       out  1        read request; held high until imem_ack
//  imem_addr      out  PC_W     read address; stable while imem_req high
//  imem_ack       in   1        read data valid this cycle; may coincide with first req cycle
//  imem_rdata     in   INSTR_W  instruction word, valid with imem_ack
//  redirect_valid in   1        1-cycle pulse from execute: take redirect_pc
//  redirect_pc    in   PC_W     redirect target
//  if_valid       out  1        if_instr / if_pc_inc valid for decode
//  id_ready       in   1        decode accepts this cycle (transfer = if_valid & id_ready)
//  if_instr       out  INSTR_W  instruction; decoder uses [15:11] as opcode
//  if_pc_inc      out  PC_W     address of if_instr + 2
//  halted         out  1        HALT consumed; fetch stopped until rst
//  if_err         out  1        misaligned redirect (only with FETCH_ALIGN_CHECK_EN; else tied 0)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=REQ, imem_req=0, if_valid=0, if_instr=16'h0800 (NOP),
//   if_pc_inc=0, halted=0, if_err=0. imem_req rises the first cycle after rst deasserts.
//  States: REQ, STALL, DRAIN, HALT_PEND, HALTED (+ ERR with macro).
//  REQ: imem_req=1, imem_addr=pc. On ack: buffer<=rdata, if_pc_inc<=pc+2, pc<=pc+2, if_valid=1
//   next cycle. Next request issued same cycle only if buffer empty or being drained this cycle;
//   otherwise ->STALL (req=0). Zero-wait memory sustains 1 instr/cycle.
//  STALL: req=0 until buffer transfers, then ->REQ.
//  HALT: fetched word with [15:11]==5'b00000 -> HALT_PEND, no further requests. Transfer of HALT
//   to decode -> HALTED: halted=1, if_valid=0, req=0; only rst exits.
//  Redirect (highest priority, except in HALTED where ignored): pc<=redirect_pc; buffer
//   cleared (if_valid=0 next cycle, even if id_ready same cycle -- no transfer counted);
//   HALT_PEND cancelled. If a request is outstanding and not acked this cycle -> DRAIN: keep
//   req high with old addr, discard data on ack, then ->REQ at new pc. Ack in same cycle as
//   redirect: data discarded, ->REQ at redirect_pc next cycle.
//  Redirect during DRAIN: pc updated again, stay in DRAIN.
//  PC arithmetic modulo 2^PC_W: pc=16'hFFFE gives if_pc_inc=16'h0000.
//  Buffer contents stable while if_valid & !id_ready.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: redirect_pc[0]==1 -> state ERR: no request, if_valid=0,
//   if_err=1 sticky until a later aligned redirect (->REQ, if_err=0) or rst.
//  Not defined: redirect_pc[0] forced to 0; if_err tied 0; no ERR state.
// STRUCTURE
//  Constants in shared opcodes.v: OP_HALT (5'b00000), NOP_INSTR (16'h0800), state encodings.
//  Sub-module fetch_out_buf: 1-entry valid/ready holding register (instr, pc_inc, flush input).
//  FSM, PC register and imem handshake stay in fetch_stage.
// TESTING
//  Zero-wait mem, id_ready=1, words 0x4001,0x4002 at 0,2 -> if_valid back-to-back, if_pc_inc 2,4.
//  3-cycle ack latency -> imem_req/addr stable 3 cycles; one instr per 4 cycles; no duplicates.
//  id_ready=0 for 5 cycles with buffer full -> imem_req=0 (STALL), if_instr unchanged; resumes.
//  Redirect to 0x0040 while ack pending -> DRAIN, stale word never valid; next addr 0x0040.
//  HALT word at 0x0006, consumed -> halted=1, no further req; redirect before consume cancels it.
//  With macro: redirect_pc=0x0013 -> if_err=1, no req; redirect 0x0020 -> if_err=0, fetch 0x0020.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
//------------------------------------------------------------------------------
// fetch_stage_pkg : opcode constants and FSM state encoding for the fetch stage.
// Optional build macro: FETCH_ALIGN_CHECK_EN (adds the ERR state).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_stage_pkg;

  localparam logic [4:0]  c_OP_HALT   = 5'b00000;
  localparam logic [15:0] c_NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    ST_REQ       = 3'd0,
    ST_STALL     = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_HALT_PEND = 3'd3,
    ST_HALTED    = 3'd4
`ifdef FETCH_ALIGN_CHECK_EN
    , ST_ERR     = 3'd5
`endif
  } fetch_state_e;

  function automatic logic is_halt(input logic [4:0] i_opcode);
    return i_opcode == c_OP_HALT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_out_buf.sv
//------------------------------------------------------------------------------
// fetch_out_buf : 1-entry valid/ready holding register between fetch and decode.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_out_buf #(
  parameter int                  PC_W        = 16,
  parameter int                  INSTR_W     = 16,
  parameter logic [INSTR_W-1:0]  RESET_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc_inc,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc_inc,
  output logic               o_fire
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_inc;

  // A flush wins over a simultaneous ready: the entry is dropped, not handed over.
  assign o_fire = r_valid & i_ready & ~i_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_instr  <= RESET_INSTR;
      r_pc_inc <= '0;
    end else begin
      if (i_flush)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
      else if (o_fire)
        r_valid <= 1'b0;

      if (i_load && !i_flush) begin
        r_instr  <= i_instr;
        r_pc_inc <= i_pc_inc;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_instr  = r_instr;
  assign o_pc_inc = r_pc_inc;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage : PC, single-outstanding imem request FSM, redirect/HALT handling.
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned redirect -> ERR, if_err).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int             PC_W     = 16,
  parameter int             INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc_inc,
  output logic               halted,
  output logic               if_err
);

  fetch_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_redir_pc;
  logic [PC_W-1:0] r_drain_addr, w_addr;
  logic            w_req, w_ack, w_redirect, w_buf_free;
  logic            w_fire, w_load, w_drain_cap, w_pending;

  assign w_pc_inc   = r_pc + PC_W'(2);
  assign w_redirect = redirect_valid & (r_state != ST_HALTED);
  assign w_buf_free = ~if_valid | id_ready;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err;
  assign w_redir_pc = redirect_pc;
  assign if_err     = r_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_redirect)
      r_err <= redirect_pc[0];
  end
`else
  assign w_redir_pc = redirect_pc & ~PC_W'(1);
  assign if_err     = 1'b0;
`endif

  // A new request only goes out when the buffer can take its data.
  always_comb begin
    w_req  = 1'b0;
    w_addr = r_pc;
    case (r_state)
      ST_REQ:   w_req = w_buf_free;
      ST_DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
      end
      default: ;
    endcase
  end

  assign w_ack     = imem_ack & w_req;
  assign w_pending = w_req & ~w_ack;
  assign imem_req  = w_req & ~rst;
  assign imem_addr = w_addr;
  assign halted    = (r_state == ST_HALTED);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_drain_cap = 1'b0;
    if (w_redirect) begin
      w_pc_nxt = w_redir_pc;
      if (w_pending) begin
        w_state_nxt = ST_DRAIN;
        w_drain_cap = (r_state != ST_DRAIN);
      end else begin
        w_state_nxt = ST_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[0])
          w_state_nxt = ST_ERR;
`endif
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_ack) begin
            w_load      = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = is_halt(imem_rdata[INSTR_W-1 -: 5]) ? ST_HALT_PEND : ST_REQ;
          end else if (!w_buf_free) begin
            w_state_nxt = ST_STALL;
          end
        end
        ST_STALL:
          if (w_buf_free) w_state_nxt = ST_REQ;
        ST_DRAIN: begin
          if (w_ack) begin
`ifdef FETCH_ALIGN_CHECK_EN
            w_state_nxt = r_err ? ST_ERR : ST_REQ;
`else
            w_state_nxt = ST_REQ;
`endif
          end
        end
        ST_HALT_PEND:
          if (w_fire) w_state_nxt = ST_HALTED;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_drain_cap)
        r_drain_addr <= w_addr;
    end
  end

  fetch_out_buf #(
    .PC_W        (PC_W),
    .INSTR_W     (INSTR_W),
    .RESET_INSTR (INSTR_W'(c_NOP_INSTR))
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (w_redirect),
    .i_load   (w_load),
    .i_instr  (imem_rdata),
    .i_pc_inc (w_pc_inc),
    .i_ready  (id_ready),
    .o_valid  (if_valid),
    .o_instr  (if_instr),
    .o_pc_inc (if_pc_inc),
    .o_fire   (w_fire)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_fetch_stage : directed vector table plus hand-written corner sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        if_valid, halted, if_err;
  logic        id_ready = 1'b1;
  logic [15:0] if_instr, if_pc_inc;

  int          lat  = 0;
  int          wcnt = 0;
  int          nerr = 0;
  int          nchk = 0;
  logic [15:0] mem [0:127];

  always #5 clk = ~clk;

  // Memory model: ack after 'lat' wait cycles; word at byte addr A is 0x4001 + A/2.
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = mem[imem_addr[7:1]];

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_instr       (if_instr),
    .if_pc_inc      (if_pc_inc),
    .halted         (halted),
    .if_err         (if_err)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] instr;
    logic [15:0] pcinc;
    logic        dat;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = 16'(16'h4001 + i);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic wait_valid(input int n, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (if_valid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    fill_mem();
    //             rst   rdy   req   addr      vld   instr     pc_inc    dat
    tv[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b1};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b1};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h4001, 16'h0002, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4002, 16'h0004, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4002, 16'h0004, 1'b1};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4002, 16'h0004, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4002, 16'h0004, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4002, 16'h0004, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4002, 16'h0004, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tv[10] = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h4003, 16'h0006, 1'b1};
    tv[11] = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h4004, 16'h0008, 1'b1};

    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = tv[i].rst; id_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d req", i), imem_req, tv[i].req);
      if (tv[i].req) chk($sformatf("v%0d addr", i), imem_addr, tv[i].addr);
      chk($sformatf("v%0d valid", i), if_valid, tv[i].vld);
      if (tv[i].dat) begin
        chk($sformatf("v%0d instr", i), if_instr, tv[i].instr);
        chk($sformatf("v%0d pc_inc", i), if_pc_inc, tv[i].pcinc);
        chk($sformatf("v%0d halted", i), halted, 1'b0);
        chk($sformatf("v%0d if_err", i), if_err, 1'b0);
      end
    end

    // 3-wait-cycle memory: request held stable, one instruction per 4 cycles.
    lat = 3; do_reset();
    begin
      int xfer = 0; int last = 0;
      logic [15:0] paddr = 16'h0; logic preq = 1'b0; logic pack = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        if (c > 1) begin @(negedge clk); #1; end
        if (preq && !pack) chk("lat addr hold", {imem_req, imem_addr}, {1'b1, paddr});
        if (if_valid && id_ready) begin
          chk("lat instr", if_instr, 32'(16'h4001 + xfer));
          if (xfer > 0) chk("lat spacing", c - last, 4);
          xfer++; last = c;
        end
        preq = imem_req; pack = imem_ack; paddr = imem_addr;
      end
      chk("lat count", xfer, 3);
    end

    // Redirect while ack pending: drain old request, stale word never surfaces.
    do_reset();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("drain req", imem_req, 1'b1);
    chk("drain addr", imem_addr, 16'h0000);
    @(negedge clk); #1;
    chk("drain ack", imem_ack, 1'b1);
    chk("drain valid", if_valid, 1'b0);
    @(negedge clk); #1;
    chk("redir req", imem_req, 1'b1);
    chk("redir addr", imem_addr, 16'h0040);
    chk("drain no stale", if_valid, 1'b0);
    wait_valid(20, ok);
    chk("redir timeout", ok, 1'b1);
    if (ok) begin
      chk("redir instr", if_instr, 16'h4021);
      chk("redir pc_inc", if_pc_inc, 16'h0042);
    end

    // HALT word at 0x0006 consumed -> halted, no more requests, redirect ignored.
    lat = 0; mem[3] = 16'h0000; do_reset();
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (if_valid && if_instr == 16'h0000) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("halt seen", ok, 1'b1);
    chk("halt pc_inc", if_pc_inc, 16'h0008);
    chk("halt pend req", imem_req, 1'b0);
    @(negedge clk); #1;
    chk("halted", halted, 1'b1);
    chk("halted valid", if_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    begin
      int nreq = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); redirect_valid = 1'b0; #1;
        if (imem_req) nreq++;
      end
      chk("halted no req", nreq, 0);
      chk("halted sticky", halted, 1'b1);
    end

    // Redirect before HALT is consumed cancels it.
    do_reset();
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (if_valid && if_instr == 16'h0000) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("cancel halt seen", ok, 1'b1);
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
    @(negedge clk); redirect_valid = 1'b0; id_ready = 1'b1; #1;
    chk("cancel halted", halted, 1'b0);
    chk("cancel valid", if_valid, 1'b0);
    chk("cancel addr", {imem_req, imem_addr}, {1'b1, 16'h0040});
    @(negedge clk); #1;
    chk("cancel instr", {if_valid, if_instr}, {1'b1, 16'h4021});
    repeat (6) @(negedge clk);
    #1;
    chk("cancel not halted", halted, 1'b0);

    // Redirect coinciding with ack, PC wrap, flush beating ready, odd target.
    fill_mem(); do_reset();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE; #1;
    chk("ack+redir ack", imem_ack, 1'b1);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("ack+redir discard", if_valid, 1'b0);
    chk("ack+redir addr", imem_addr, 16'hFFFE);
    @(negedge clk); #1;
    chk("wrap instr", {if_valid, if_instr}, {1'b1, 16'h4080});
    chk("wrap pc_inc", if_pc_inc, 16'h0000);
    chk("wrap addr", imem_addr, 16'h0000);
    redirect_valid = 1'b1; redirect_pc = 16'h0010; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("flush beats ready", if_valid, 1'b0);
    chk("flush addr", imem_addr, 16'h0010);
    @(negedge clk); #1;
    chk("flush instr", {if_valid, if_instr, if_pc_inc}, {1'b1, 16'h4009, 16'h0012});
    redirect_valid = 1'b1; redirect_pc = 16'h0013; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign err", if_err, 1'b1);
    chk("misalign no req", imem_req, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 16'h0020; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("realign err", if_err, 1'b0);
    chk("realign addr", {imem_req, imem_addr}, {1'b1, 16'h0020});
`else
    chk("odd if_err", if_err, 1'b0);
    chk("odd addr", {imem_req, imem_addr}, {1'b1, 16'h0012});
    @(negedge clk); #1;
    chk("odd instr", {if_valid, if_instr, if_pc_inc}, {1'b1, 16'h400A, 16'h0014});
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
